ball_ctl: RTL

//  Ball physics controller; drives the top-left sprite position (xpos/ypos) that the ball renderer consumes.

---
 rtl/ball_ctl_pkg.sv | 47 ++++
 rtl/ball_ctl_frame_tick.sv | 18 +
 rtl/ball_ctl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ball_ctl_pkg.sv
// Shared constants and types for the ball controller: geometry, physics tuning,
// FSM state encoding and the serve-position helper.
package ball_ctl_pkg;

    localparam int BALL_SIZE = 64;
    localparam int SCREEN_W  = 800;
    localparam int GROUND_Y  = 536;
    localparam int NET_X     = 400;
    localparam int SERVE_XL  = 150;
    localparam int SERVE_XR  = 586;
    localparam int SERVE_Y   = 100;
    localparam int GRAV_DIV  = 2;
    localparam int BOUNCE_VY = 12;
    localparam int BOUNCE_VX = 4;
    localparam int MAX_VY    = 15;
    localparam int NET_CD    = 4;
    localparam int HOLD_FR   = 60;

    typedef logic signed [12:0] pos_t;
    typedef logic signed [7:0]  vel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLY    = 2'd1,
        ST_SCORED = 2'd2
    } ball_state_t;

    // Width-matched copies of the tuning constants used by the datapath.
    localparam pos_t       P_SERVE_XL  = pos_t'(SERVE_XL);
    localparam pos_t       P_SERVE_XR  = pos_t'(SERVE_XR);
    localparam pos_t       P_SERVE_Y   = pos_t'(SERVE_Y);
    localparam pos_t       P_X_MAX     = pos_t'(SCREEN_W - BALL_SIZE);
    localparam pos_t       P_GROUND_Y  = pos_t'(GROUND_Y);
    localparam pos_t       P_NET_X     = pos_t'(NET_X);
    localparam pos_t       P_HALF_BALL = pos_t'(BALL_SIZE / 2);
    localparam vel_t       V_BOUNCE_VY = vel_t'(BOUNCE_VY);
    localparam vel_t       V_BOUNCE_VX = vel_t'(BOUNCE_VX);
    localparam vel_t       V_MAX_VY    = vel_t'(MAX_VY);
    localparam logic [3:0] GRAV_LAST   = 4'(GRAV_DIV - 1);
    localparam logic [2:0] CD_LOAD     = 3'(NET_CD);
    localparam logic [6:0] HOLD_LAST   = 7'(HOLD_FR - 1);

    function automatic pos_t serve_x(input logic side);
        return side ? P_SERVE_XR : P_SERVE_XL;
    endfunction

endpackage

// File: rtl/ball_ctl_frame_tick.sv
// Rising-edge detector on vsync: one-cycle tick at the start of every frame.
module frame_tick (
    input  logic pclk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);

    logic vsync_d;

    always_ff @(posedge pclk) begin
        if (rst) vsync_d <= 1'b0;
        else     vsync_d <= vsync;
    end

    assign tick = vsync & ~vsync_d;

endmodule

// File: rtl/ball_ctl.sv
// Ball physics controller: once per frame applies collisions, gravity, wall and
// ground handling, and sequences serve -> flight -> point -> idle.
module ball_ctl
    import ball_ctl_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        serve,
    input  logic        serve_side,
    input  logic        pl1_col,
    input  logic        pl2_col,
    input  logic        net_col,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        in_play,
    output logic        point_pl1,
    output logic        point_pl2
);

    ball_state_t state_q, state_d;
    pos_t        x_q, x_d, y_q, y_d, x_n, y_n;
    vel_t        vx_q, vx_d, vy_q, vy_d, vx_n, vy_n;
    logic [3:0]  grav_q, grav_d;
    logic [2:0]  cd_q, cd_d;
    logic [6:0]  hold_q, hold_d;
    logic        scorer_q, scorer_d;
    logic        stk_pl1_q, stk_pl1_d, stk_pl2_q, stk_pl2_d, stk_net_q, stk_net_d;
    logic        p1_q, p1_d, p2_q, p2_d;
    logic        tick, eff_pl1, eff_pl2, eff_net;

    frame_tick u_frame_tick (
        .pclk  (pclk),
        .rst   (rst),
        .vsync (vsync),
        .tick  (tick)
    );

    // Per-pixel flags are only valid mid-frame, so they are held until the tick.
    assign eff_pl1 = stk_pl1_q | pl1_col;
    assign eff_pl2 = stk_pl2_q | pl2_col;
    assign eff_net = stk_net_q | net_col;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= P_SERVE_XL;
            y_q       <= P_SERVE_Y;
            vx_q      <= '0;
            vy_q      <= '0;
            grav_q    <= '0;
            cd_q      <= '0;
            hold_q    <= '0;
            scorer_q  <= 1'b0;
            stk_pl1_q <= 1'b0;
            stk_pl2_q <= 1'b0;
            stk_net_q <= 1'b0;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            grav_q    <= grav_d;
            cd_q      <= cd_d;
            hold_q    <= hold_d;
            scorer_q  <= scorer_d;
            stk_pl1_q <= stk_pl1_d;
            stk_pl2_q <= stk_pl2_d;
            stk_net_q <= stk_net_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        grav_d    = grav_q;
        cd_d      = cd_q;
        hold_d    = hold_q;
        scorer_d  = scorer_q;
        p1_d      = 1'b0;
        p2_d      = 1'b0;
        x_n       = x_q;
        y_n       = y_q;
        vx_n      = vx_q;
        vy_n      = vy_q;
        stk_pl1_d = tick ? 1'b0 : eff_pl1;
        stk_pl2_d = tick ? 1'b0 : eff_pl2;
        stk_net_d = tick ? 1'b0 : eff_net;

        case (state_q)
            ST_IDLE: begin
                x_d  = serve_x(serve_side);
                y_d  = P_SERVE_Y;
                vx_d = '0;
                vy_d = '0;
                if (serve) begin
                    state_d   = ST_FLY;
                    grav_d    = '0;
                    cd_d      = '0;
                    stk_pl1_d = 1'b0;
                    stk_pl2_d = 1'b0;
                    stk_net_d = 1'b0;
                end
            end

            ST_FLY: begin
                if (tick) begin
                    if (eff_pl1) begin
                        vy_n = -V_BOUNCE_VY;
                        vx_n = V_BOUNCE_VX;
                    end else if (eff_pl2) begin
                        vy_n = -V_BOUNCE_VY;
                        vx_n = -V_BOUNCE_VX;
                    end else if (eff_net && cd_q == 3'd0) begin
                        vx_n = -vx_q;
                        cd_d = CD_LOAD;
                    end else if (cd_q != 3'd0) begin
                        cd_d = cd_q - 3'd1;
                    end

                    if (grav_q == GRAV_LAST) begin
                        grav_d = '0;
                        vy_n   = (vy_n >= V_MAX_VY) ? V_MAX_VY : vy_n + 8'sd1;
                    end else begin
                        grav_d = grav_q + 4'd1;
                    end

                    x_n = x_q + {{5{vx_n[7]}}, vx_n};
                    y_n = y_q + {{5{vy_n[7]}}, vy_n};

                    if (x_n[12]) begin
                        x_n  = '0;
                        vx_n = vx_n[7] ? -vx_n : vx_n;
                    end else if (x_n > P_X_MAX) begin
                        x_n  = P_X_MAX;
                        vx_n = vx_n[7] ? vx_n : -vx_n;
                    end
                    if (y_n[12]) begin
                        y_n  = '0;
                        vy_n = '0;
                    end

                    // Landing side is judged on the ball centre; the other player scores.
                    if (y_n >= P_GROUND_Y) begin
                        y_n     = P_GROUND_Y;
                        vx_n    = '0;
                        vy_n    = '0;
                        hold_d  = '0;
                        state_d = ST_SCORED;
                        if (x_n + P_HALF_BALL < P_NET_X) begin
                            p2_d     = 1'b1;
                            scorer_d = 1'b1;
                        end else begin
                            p1_d     = 1'b1;
                            scorer_d = 1'b0;
                        end
                    end

                    x_d  = x_n;
                    y_d  = y_n;
                    vx_d = vx_n;
                    vy_d = vy_n;
                end
            end

            ST_SCORED: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        x_d     = serve_x(scorer_q);
                        y_d     = P_SERVE_Y;
                    end else begin
                        hold_d = hold_q + 7'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign xpos      = x_q[11:0];
    assign ypos      = y_q[11:0];
    assign in_play   = (state_q == ST_FLY);
    assign point_pl1 = p1_q;
    assign point_pl2 = p2_q;

endmodule
